// File: rtl/hc165_pkg.sv
// Shared types and constants for the 74HC165 chain reader.
//   hc165_state_t : scan controller state encoding
//   HC165_BITS    : parallel inputs per 74HC165 device
package hc165_pkg;

  localparam int unsigned HC165_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShLo,
    StShHi,
    StDone
  } hc165_state_t;

endpackage

// File: rtl/hc165_phase_timer.sv
// Loadable down-counter that times each controller phase.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : reload the count with load_val (has priority over counting)
//   load_val    : reload value, phase length minus one
//   phase_done  : high while the count is zero (last cycle of the phase)
module hc165_phase_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             phase_done
);

  logic [Width-1:0] count_q, count_d;

  // Counting stops at zero so an unserviced phase never wraps.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign phase_done = (count_q == '0);

endmodule

// File: rtl/hc165_reader.sv
// Scan controller for a daisy chain of CHAIN 74HC165 shift registers.
// Generates SH/LD, CLK INH and the serial clock, samples qh once per bit
// and publishes the assembled word with a one-cycle valid strobe.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : scan request, honoured only when idle
//   auto_en         : restart a scan immediately after each completed one
//   qh              : serial data from the last device of the chain
//   shift_load      : device SH/LD (0 = parallel load)
//   clock_in_hibit  : device CLK INH (1 = shifting inhibited)
//   sclk            : device serial clock
//   busy            : scan in progress
//   data            : last complete word, first received bit in the MSB
//   data_valid      : one-cycle pulse when data updates
module hc165_reader
  import hc165_pkg::*;
#(
  parameter int unsigned CHAIN = 1,
  parameter int unsigned DIV   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         auto_en,
  input  logic                         qh,
  output logic                         shift_load,
  output logic                         clock_in_hibit,
  output logic                         sclk,
  output logic                         busy,
  output logic [HC165_BITS*CHAIN-1:0] data,
  output logic                         data_valid
);

  localparam int unsigned W    = HC165_BITS * CHAIN;
  localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [IdxW-1:0] LastIdx   = IdxW'(W - 1);
  localparam logic [CntW-1:0] PhaseLoad = CntW'(DIV - 1);

  hc165_state_t    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    cap_q, cap_d;
  logic [W-1:0]    data_q, data_d;
  logic            phase_done, phase_load;

  logic shift_load_q, shift_load_d;
  logic inh_q, inh_d;
  logic sclk_q, sclk_d;
  logic busy_q, busy_d;
  logic valid_q, valid_d;

  // Every state entry starts a fresh DIV-cycle phase; idle keeps it primed.
  assign phase_load = (state_d != state_q) || (state_q == StIdle);

  hc165_phase_timer #(
    .Width (CntW)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (phase_load),
    .load_val   (PhaseLoad),
    .phase_done (phase_done)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (phase_done) begin
          state_d = StShLo;
          idx_d   = '0;
        end
      end
      StShLo: begin
        if (phase_done) begin
          cap_d[LastIdx - idx_q] = qh;
          state_d                = StShHi;
        end
      end
      // The last bit still occupies a high-phase slot (with sclk held low) so
      // a frame is DIV*(2W+1) cycles from load to the valid strobe.
      StShHi: begin
        if (phase_done) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StShLo;
          end
        end
      end
      StDone: begin
        idx_d   = '0;
        state_d = auto_en ? StLoad : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state they belong to.
  always_comb begin
    shift_load_d = (state_d != StLoad);
    inh_d        = !((state_d == StShLo) || (state_d == StShHi));
    sclk_d       = (state_d == StShHi) && (idx_d != LastIdx);
    busy_d       = (state_d != StIdle);
    valid_d      = (state_d == StDone);
    data_d       = valid_d ? cap_d : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cap_q        <= '0;
      data_q       <= '0;
      shift_load_q <= 1'b1;
      inh_q        <= 1'b1;
      sclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cap_q        <= cap_d;
      data_q       <= data_d;
      shift_load_q <= shift_load_d;
      inh_q        <= inh_d;
      sclk_q       <= sclk_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  assign shift_load     = shift_load_q;
  assign clock_in_hibit = inh_q;
  assign sclk           = sclk_q;
  assign busy           = busy_q;
  assign data           = data_q;
  assign data_valid     = valid_q;

endmodule
